// File: rtl/set_assoc_cache_ctrl_if.sv
// CPU request/response and backing-memory bus of the set-associative cache
// controller. The controller takes the slave view; the core and the memory
// behind it together form the master view.
interface set_assoc_cache_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // CPU request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  // CPU response channel
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  // Backing-memory channel
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative, write-back / write-allocate cache controller with
// true-LRU replacement, one word per line, a blocking backing-memory port and
// saturating per-type hit/miss statistics.
module set_assoc_cache_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int SETS   = 8,
  parameter int WAYS   = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  set_assoc_cache_ctrl_if.slave bus,
  output logic [CNT_W-1:0]      read_hit,
  output logic [CNT_W-1:0]      read_miss,
  output logic [CNT_W-1:0]      write_hit,
  output logic [CNT_W-1:0]      write_miss
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int AGE_W = $clog2(WAYS);
  localparam int WAY_W = AGE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND
  } state_t;

  state_t state_q, state_d;

  // Line storage and replacement state
  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];

  // Captured request
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [IDX_W-1:0]  cap_set;
  logic [TAG_W-1:0]  cap_tag;

  assign cap_set = cap_addr[IDX_W-1:0];
  assign cap_tag = cap_addr[ADDR_W-1:IDX_W];

  // Lookup / replacement results
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  lookup_victim;
  logic [WAY_W-1:0]  vic_q;
  logic [WAY_W-1:0]  acc_way;
  logic [AGE_W-1:0]  age_new [WAYS];
  logic [DATA_W-1:0] rdata_q;

  logic lookup_hit;
  logic lookup_miss;
  logic refill_done;
  logic lru_touch;

  assign lookup_hit  = (state_q == S_LOOKUP) && hit;
  assign lookup_miss = (state_q == S_LOOKUP) && !hit;
  assign refill_done = (state_q == S_REFILL) && bus.mem_ack;
  assign lru_touch   = lookup_hit || refill_done;
  // The line being touched is the hit way in LOOKUP and the victim on refill.
  assign acc_way     = (state_q == S_LOOKUP) ? hit_way : vic_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Tag compare across all valid ways of the captured set.
  // NOTE: every variable written in an always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[cap_set][w] && (tag_q[cap_set][w] == cap_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest-index invalid way, else the least recently used.
  always_comb begin
    logic found_inv;
    found_inv     = 1'b0;
    lookup_victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[cap_set][w]) begin
        found_inv     = 1'b1;
        lookup_victim = WAY_W'(w);
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[cap_set][w] == AGE_W'(WAYS - 1)) lookup_victim = WAY_W'(w);
      end
    end
  end

  // LRU ages after touching acc_way: it becomes youngest, younger ways age by one.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == acc_way) begin
        age_new[w] = '0;
      end else if (age_q[cap_set][w] < age_q[cap_set][acc_way]) begin
        age_new[w] = age_q[cap_set][w] + AGE_W'(1);
      end else begin
        age_new[w] = age_q[cap_set][w];
      end
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and bus outputs, all decoded from the current state.
  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    unique case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit)                                   state_d = S_RESPOND;
        else if (valid_q[cap_set][lookup_victim] &&
                 dirty_q[cap_set][lookup_victim])  state_d = S_WRITEBACK;
        else                                       state_d = S_REFILL;
      end
      S_WRITEBACK: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {tag_q[cap_set][vic_q], cap_set};
        bus.mem_wdata = data_q[cap_set][vic_q];
        if (bus.mem_ack) state_d = S_REFILL;
      end
      S_REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = cap_addr;
        if (bus.mem_ack) state_d = S_RESPOND;
      end
      S_RESPOND: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, victim latch and response data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      vic_q     <= '0;
      rdata_q   <= '0;
    end else begin
      if (state_q == S_IDLE && bus.req_valid) begin
        cap_we    <= bus.req_we;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
      end
      if (lookup_miss) vic_q <= lookup_victim;
      if (lookup_hit)       rdata_q <= cap_we ? '0 : data_q[cap_set][hit_way];
      else if (refill_done) rdata_q <= cap_we ? '0 : bus.mem_rdata;
    end
  end

  // Valid, dirty and LRU state: cleared on reset so every set starts empty
  // with ages 0..WAYS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      if (lookup_hit && cap_we) dirty_q[cap_set][hit_way] <= 1'b1;
      if (refill_done) begin
        valid_q[cap_set][vic_q] <= 1'b1;
        dirty_q[cap_set][vic_q] <= cap_we;
      end
      if (lru_touch) begin
        for (int w = 0; w < WAYS; w++) age_q[cap_set][w] <= age_new[w];
      end
    end
  end

  // Tag and data arrays.
  // NOTE: storage arrays are deliberately left out of reset; valid bits gate
  // every use, and a reset would prevent mapping them onto RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (lookup_hit && cap_we) data_q[cap_set][hit_way] <= cap_wdata;
      if (refill_done) begin
        tag_q[cap_set][vic_q]  <= cap_tag;
        data_q[cap_set][vic_q] <= cap_we ? cap_wdata : bus.mem_rdata;
      end
    end
  end

  // Saturating statistics: exactly one counter steps per LOOKUP.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_hit   <= '0;
      read_miss  <= '0;
      write_hit  <= '0;
      write_miss <= '0;
    end else if (state_q == S_LOOKUP) begin
      unique case ({cap_we, hit})
        2'b01:   read_hit   <= sat_inc(read_hit);
        2'b00:   read_miss  <= sat_inc(read_miss);
        2'b11:   write_hit  <= sat_inc(write_hit);
        default: write_miss <= sat_inc(write_miss);
      endcase
    end
  end

endmodule
